// File: rtl/axi_timer_pkg.sv
// Shared widths and constants for the timer measurement statistics path.
package axi_timer_pkg;

    localparam int MSMT_W = 32;

    localparam logic [MSMT_W-1:0] STAT_MIN_INIT = 32'hFFFFFFFF;
    localparam logic [MSMT_W-1:0] CNT_SAT       = 32'hFFFFFFFF;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [MSMT_W-1:0] sat_inc(input logic [MSMT_W-1:0] v);
        return (v == CNT_SAT) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/msmt_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with distributed-RAM storage,
// synchronous reset and synchronous flush.
module msmt_sync_fifo #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push,
    input  logic [DATA_W-1:0]     din,
    output logic                  full,
    input  logic                  pop,
    output logic [DATA_W-1:0]     dout,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [DATA_W-1:0]     mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  do_push, do_pop;

    // Full is taken from the registered level, so a same-cycle pop never frees a slot.
    assign full    = (level_q == LEVEL_FULL);
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst && !flush) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/axi_timer_msmt_stats.sv
// Running statistics over single-shot timer measurements, with a FIFO that
// forwards every accepted measurement over an AXI-Stream master port.
module axi_timer_msmt_stats
    import axi_timer_pkg::*;
#(
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [MSMT_W-1:0]          MSMT_VALUE,
    input  logic                       MSMT_VALID,
    input  logic                       CLEAR,
    output logic [MSMT_W-1:0]          MIN_VALUE,
    output logic [MSMT_W-1:0]          MAX_VALUE,
    output logic [MSMT_W-1:0]          LAST_VALUE,
    output logic [MSMT_W-1:0]          SAMPLE_COUNT,
    output logic [MSMT_W-1:0]          DROP_COUNT,
    output logic                       STATS_VALID,
    output logic [FIFO_DEPTH_LOG2:0]   FIFO_LEVEL,
    output logic [MSMT_W-1:0]          M_AXIS_TDATA,
    output logic                       M_AXIS_TVALID,
    input  logic                       M_AXIS_TREADY
);

    logic [MSMT_W-1:0] min_q, min_d;
    logic [MSMT_W-1:0] max_q, max_d;
    logic [MSMT_W-1:0] last_q, last_d;
    logic [MSMT_W-1:0] sample_count_q, sample_count_d;
    logic [MSMT_W-1:0] drop_count_q, drop_count_d;
    logic              stats_valid_q, stats_valid_d;
    logic              fifo_full, fifo_empty;

    // Statistics update even when the FIFO rejects the sample; the reject only bumps the drop count.
    always_comb begin
        min_d          = min_q;
        max_d          = max_q;
        last_d         = last_q;
        sample_count_d = sample_count_q;
        drop_count_d   = drop_count_q;
        stats_valid_d  = stats_valid_q;
        if (CLEAR) begin
            min_d          = STAT_MIN_INIT;
            max_d          = '0;
            last_d         = '0;
            sample_count_d = '0;
            drop_count_d   = '0;
            stats_valid_d  = 1'b0;
        end else if (MSMT_VALID) begin
            last_d         = MSMT_VALUE;
            min_d          = (MSMT_VALUE < min_q) ? MSMT_VALUE : min_q;
            max_d          = (MSMT_VALUE > max_q) ? MSMT_VALUE : max_q;
            sample_count_d = sat_inc(sample_count_q);
            stats_valid_d  = 1'b1;
            if (fifo_full) drop_count_d = sat_inc(drop_count_q);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            min_q          <= STAT_MIN_INIT;
            max_q          <= '0;
            last_q         <= '0;
            sample_count_q <= '0;
            drop_count_q   <= '0;
            stats_valid_q  <= 1'b0;
        end else begin
            min_q          <= min_d;
            max_q          <= max_d;
            last_q         <= last_d;
            sample_count_q <= sample_count_d;
            drop_count_q   <= drop_count_d;
            stats_valid_q  <= stats_valid_d;
        end
    end

    msmt_sync_fifo #(
        .DATA_W     (MSMT_W),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RESET),
        .flush (CLEAR),
        .push  (MSMT_VALID),
        .din   (MSMT_VALUE),
        .full  (fifo_full),
        .pop   (M_AXIS_TREADY),
        .dout  (M_AXIS_TDATA),
        .empty (fifo_empty),
        .level (FIFO_LEVEL)
    );

    assign M_AXIS_TVALID = !fifo_empty;
    assign MIN_VALUE     = min_q;
    assign MAX_VALUE     = max_q;
    assign LAST_VALUE    = last_q;
    assign SAMPLE_COUNT  = sample_count_q;
    assign DROP_COUNT    = drop_count_q;
    assign STATS_VALID   = stats_valid_q;

endmodule

// File: tb/tb_axi_timer_msmt_stats.sv
// Self-checking bench: a queue-based reference model is compared against the
// DUT every cycle, with hand-computed literal checks at scenario boundaries.
module tb_axi_timer_msmt_stats;

    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic                clock;
    logic                reset;
    logic [31:0]         msmt_value;
    logic                msmt_valid;
    logic                clear;
    logic [31:0]         min_value, max_value, last_value;
    logic [31:0]         sample_count, drop_count;
    logic                stats_valid;
    logic [DEPTH_LOG2:0] fifo_level;
    logic [31:0]         m_axis_tdata;
    logic                m_axis_tvalid;
    logic                m_axis_tready;

    int assertions = 0;
    int failures   = 0;
    int beats      = 0;

    // Reference model state
    logic        model_ready = 1'b0;
    logic [31:0] m_min, m_max, m_last, m_count, m_drop;
    logic        m_valid;
    logic [31:0] m_q[$];
    int          m_size;

    axi_timer_msmt_stats #(.FIFO_DEPTH_LOG2(DEPTH_LOG2)) dut (
        .CLK           (clock),
        .RESET         (reset),
        .MSMT_VALUE    (msmt_value),
        .MSMT_VALID    (msmt_valid),
        .CLEAR         (clear),
        .MIN_VALUE     (min_value),
        .MAX_VALUE     (max_value),
        .LAST_VALUE    (last_value),
        .SAMPLE_COUNT  (sample_count),
        .DROP_COUNT    (drop_count),
        .STATS_VALID   (stats_valid),
        .FIFO_LEVEL    (fifo_level),
        .M_AXIS_TDATA  (m_axis_tdata),
        .M_AXIS_TVALID (m_axis_tvalid),
        .M_AXIS_TREADY (m_axis_tready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Inputs change on the falling edge; beats counts handshakes that the next rising edge will take.
    task automatic applyStimulus(input logic v, input logic [31:0] val, input logic clr,
                                 input logic rdy, input logic rst);
        @(negedge clock);
        reset         = rst;
        clear         = clr;
        msmt_valid    = v;
        msmt_value    = val;
        m_axis_tready = rdy;
        #1;
        if (!rst && !clr && m_axis_tvalid && m_axis_tready) beats++;
    endtask

    task automatic modelInit();
        m_min   = 32'hFFFFFFFF;
        m_max   = 32'h0;
        m_last  = 32'h0;
        m_count = 32'h0;
        m_drop  = 32'h0;
        m_valid = 1'b0;
        m_q.delete();
    endtask

    // Model: stats follow plain min/max/saturating-count rules; the FIFO is a queue
    // whose capacity is judged before any pop of the same cycle.
    always @(posedge clock) begin
        if (reset) begin
            modelInit();
            model_ready = 1'b1;
        end else if (clear) begin
            modelInit();
        end else if (model_ready) begin
            m_size = m_q.size();
            if (m_axis_tready && m_size > 0) void'(m_q.pop_front());
            if (msmt_valid) begin
                m_last  = msmt_value;
                if (msmt_value < m_min) m_min = msmt_value;
                if (msmt_value > m_max) m_max = msmt_value;
                if (m_count != 32'hFFFFFFFF) m_count = m_count + 1;
                m_valid = 1'b1;
                if (m_size < DEPTH) m_q.push_back(msmt_value);
                else if (m_drop != 32'hFFFFFFFF) m_drop = m_drop + 1;
            end
        end
    end

    always @(negedge clock) begin
        if (model_ready) begin
            checkOutput("min",         min_value,            m_min);
            checkOutput("max",         max_value,            m_max);
            checkOutput("last",        last_value,           m_last);
            checkOutput("sample_cnt",  sample_count,         m_count);
            checkOutput("drop_cnt",    drop_count,           m_drop);
            checkOutput("stats_valid", 32'(stats_valid),     32'(m_valid));
            checkOutput("fifo_level",  32'(fifo_level),      32'(m_q.size()));
            checkOutput("tvalid",      32'(m_axis_tvalid),   32'(m_q.size() != 0));
            if (m_q.size() != 0) checkOutput("tdata", m_axis_tdata, m_q[0]);
        end
    end

    initial begin
        reset = 1'b1; clear = 1'b0; msmt_valid = 1'b0; msmt_value = '0; m_axis_tready = 1'b0;

        // Reset, then three strobes drained immediately
        applyStimulus(0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("rst_min",   min_value,         32'hFFFFFFFF);
        checkOutput("rst_level", 32'(fifo_level),   32'd0);
        applyStimulus(1, 100, 0, 1, 0);
        applyStimulus(1, 40,  0, 1, 0);
        applyStimulus(1, 250, 0, 1, 0);
        applyStimulus(0, 0,   0, 1, 0);
        checkOutput("t1_min",   min_value,          32'd40);
        checkOutput("t1_max",   max_value,          32'd250);
        checkOutput("t1_last",  last_value,         32'd250);
        checkOutput("t1_count", sample_count,       32'd3);
        checkOutput("t1_valid", 32'(stats_valid),   32'd1);
        checkOutput("t1_tdata", m_axis_tdata,       32'd250);
        applyStimulus(0, 0, 0, 1, 0);

        // Fill past capacity with the sink stalled
        applyStimulus(0, 0, 1, 0, 0);
        for (int i = 1; i <= 20; i++) applyStimulus(1, 32'(i), 0, 0, 0);
        // Full FIFO, sink ready, strobe 99 in the same cycle
        applyStimulus(1, 99, 0, 1, 0);
        checkOutput("t2_level", 32'(fifo_level),    32'd16);
        checkOutput("t2_drop",  drop_count,         32'd4);
        checkOutput("t2_count", sample_count,       32'd20);
        checkOutput("t2_max",   max_value,          32'd20);
        checkOutput("t2_head",  m_axis_tdata,       32'd1);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("t3_drop",  drop_count,         32'd5);
        checkOutput("t3_level", 32'(fifo_level),    32'd15);
        checkOutput("t3_head",  m_axis_tdata,       32'd2);
        for (int i = 0; i < 16; i++) applyStimulus(0, 0, 0, 1, 0);
        checkOutput("t3_empty", 32'(m_axis_tvalid), 32'd0);

        // Clear wins over a coincident strobe
        applyStimulus(1, 7, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t4_min",   min_value,          32'hFFFFFFFF);
        checkOutput("t4_max",   max_value,          32'd0);
        checkOutput("t4_count", sample_count,       32'd0);
        checkOutput("t4_level", 32'(fifo_level),    32'd0);
        checkOutput("t4_valid", 32'(stats_valid),   32'd0);
        applyStimulus(1, 7, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t4_min7",  min_value,          32'd7);
        checkOutput("t4_max7",  max_value,          32'd7);
        checkOutput("t4_last7", last_value,         32'd7);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 0);

        // Toggling backpressure, 32 samples, every beat delivered exactly once
        beats = 0;
        for (int c = 0; c < 96; c++)
            applyStimulus((c % 3) == 0, $urandom, 0, c[0], 0);
        for (int c = 0; c < 40; c++) applyStimulus(0, 0, 0, c[0], 0);
        checkOutput("t5_beats", 32'(beats),         32'd32);
        checkOutput("t5_level", 32'(fifo_level),    32'd0);

        // Saturation of the sample counter via backdoor
        applyStimulus(0, 0, 0, 1, 0);
        #1;
        dut.sample_count_q = 32'hFFFFFFFE;
        m_count            = 32'hFFFFFFFE;
        for (int i = 0; i < 3; i++) applyStimulus(1, 32'(5 + i), 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("t6_sat",   sample_count,       32'hFFFFFFFF);

        // Random traffic with occasional clears
        applyStimulus(0, 0, 1, 1, 0);
        for (int c = 0; c < 400; c++)
            applyStimulus($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 49) == 0,
                          $urandom_range(0, 2) != 0, 0);
        for (int c = 0; c < 20; c++) applyStimulus(0, 0, 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
